uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104, is the number of CLK cycles per serial bit (115200 baud at 12 MHz) and SHALL be at least 2.
REQ-002 Parameter FIFO_DEPTH_LOG2, default 2, SHALL set the transmit FIFO depth to 2**FIFO_DEPTH_LOG2 bytes.
REQ-003 CLK  input  1  system clock; all logic SHALL be on its rising edge.
REQ-004 rst  input  1  reset: synchronous, active-high.
REQ-005 tx_data  input  8  byte to transmit.
REQ-006 tx_valid  input  1  tx_data is valid this cycle.
REQ-007 tx_ready  output  1  FIFO can accept a byte this cycle.
REQ-008 tx_serial  output  1  serial line, idle high.
REQ-009 tx_busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-010 fifo_count  output  FIFO_DEPTH_LOG2+1  bytes currently held in the FIFO.

Function
REQ-011 A byte SHALL be accepted only on a cycle with tx_valid && tx_ready; tx_ready SHALL equal (fifo_count != 2**FIFO_DEPTH_LOG2), combinationally from registered state.
REQ-012 Frame SHALL be start bit (0), 8 data bits LSB first, optional parity bit (REQ-024), then one stop bit (1); each bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-013 FSM states: IDLE, START, DATA, PARITY, STOP; IDLE->START when the FIFO is non-empty, START->DATA, DATA->DATA for bits 0..6, DATA->PARITY or STOP after bit 7, PARITY->STOP, STOP->START if the FIFO is non-empty at the end of the stop bit, else STOP->IDLE.
REQ-014 The FIFO SHALL be popped on the IDLE->START or STOP->START transition; the popped byte SHALL be held in a shift register for the whole frame.
REQ-015 tx_serial SHALL be registered; with the FSM in IDLE and the FIFO empty, a byte accepted in cycle N SHALL drive tx_serial low from cycle N+2.
REQ-016 Back-to-back frames SHALL have no idle gap: the next start bit begins on the cycle after the last stop-bit cycle.
REQ-017 A push and a pop in the same cycle SHALL leave fifo_count unchanged, and the bytes SHALL be transmitted in acceptance order.
REQ-018 When the FIFO is full, tx_valid SHALL be ignored (no overwrite), even in a cycle where a pop occurs.
REQ-019 The bit-period counter SHALL count 0..CLKS_PER_BIT-1 and wrap; the bit index SHALL be 3 bits, with no out-of-range index reachable.
REQ-020 tx_busy SHALL be low only when the FSM is in IDLE and fifo_count == 0.

Reset
REQ-021 While rst is high, the FSM SHALL go to IDLE, the FIFO SHALL be emptied, and the counters SHALL be cleared.
REQ-022 Output values during and after reset: tx_serial=1, tx_busy=0, fifo_count=0, tx_ready=1.
REQ-023 rst asserted mid-frame SHALL abort the frame: tx_serial SHALL be high on the cycle after the reset edge, and the partial byte and all queued bytes SHALL be discarded.

Configuration
REQ-024 With macro UART_TX_PARITY_EN defined, the PARITY state SHALL transmit an even-parity bit (XOR of the 8 data bits) and the frame SHALL be 11 bits.
REQ-025 Without UART_TX_PARITY_EN, the PARITY state logic SHALL be absent, DATA SHALL go directly to STOP, and the frame SHALL be 10 bits.

Structure
REQ-026 Package uart_pkg SHALL hold the FSM state enum, DATA_BITS=8, and the line idle/start/stop level constants; the team's UART receiver shall share them.
REQ-027 The FIFO SHALL be a sub-module uart_tx_fifo (synchronous, push/pop/count, first-word-fall-through output).

Verification
REQ-028 CLKS_PER_BIT=4, no parity: push 0xA5 when idle -> tx_serial low at N+2 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), high stop for 4 cycles; frame 40 cycles; tx_busy then low.
REQ-029 Same setup with UART_TX_PARITY_EN: push 0xA5 -> parity bit 0 after the data bits, frame 44 cycles; push 0x01 -> parity bit 1.
REQ-030 FIFO_DEPTH_LOG2=2: push 0x11,0x22,0x33,0x44,0x55 on consecutive cycles while idle -> 5 bytes accepted (one popped into the shifter), fifo_count peaks at 4, tx_ready=0; a 6th push is ignored; 5 contiguous frames in order with no idle gap.
REQ-031 Full FIFO with a pop in the same cycle as tx_valid=1 -> the byte is not accepted and fifo_count drops by 1.
REQ-032 Assert rst during data bit 3 of 0xFF with 2 bytes queued -> the next cycle tx_serial=1, fifo_count=0, tx_busy=0; after release the line stays high with no further frames.
REQ-033 Push 0x00 on the same cycle as a STOP->START pop with fifo_count=1 -> fifo_count stays 1 and 0x00 is sent in the following frame.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
// Holds the line-level constants, the data width and the frame FSM state type.
package uart_pkg;

  // Payload bits per frame.
  localparam int DATA_BITS = 8;

  // Serial line levels.
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  // Frame sequencer states. PARITY is only visited when parity is built in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Even parity: the bit that makes the total count of ones (data + parity) even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: small synchronous FIFO with first-word-fall-through output.
// The head byte is visible on pop_data whenever the FIFO is non-empty.
// Pushes into a full FIFO are dropped even when a pop happens in the same cycle.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic [DATA_BITS-1:0]  push_data,
  input  logic                  push,
  input  logic                  pop,
  output logic [DATA_BITS-1:0]  pop_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  logic [DATA_BITS-1:0]  mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  push_ok;
  logic                  pop_ok;

  assign full     = (count_q == FULL_COUNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem[rd_ptr_q];

  // Qualify requests against occupancy and advance pointers / occupancy.
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge CLK) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered UART transmitter, 8 data bits, one stop bit.
// Each bit lasts CLKS_PER_BIT clocks (must be >= 2). Frames for queued bytes
// are sent back to back with no idle gap.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between
// the last data bit and the stop bit (11-bit frame instead of 10).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT    = 104,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                       CLK,
  input  logic                       rst,
  input  logic [DATA_BITS-1:0]       tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic                       tx_serial,
  output logic                       tx_busy,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_count
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  uart_state_e           state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      bit_idx_q;
  logic [DATA_BITS-1:0]  shift_q;
  logic                  tx_serial_q;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q;
`endif

  logic                  bit_done;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_BITS-1:0]  fifo_head;

  uart_tx_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .CLK       (CLK),
    .rst       (rst),
    .push_data (tx_data),
    .push      (tx_valid),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign tx_ready  = !fifo_full;
  assign tx_serial = tx_serial_q;
  assign tx_busy   = !((state_q == ST_IDLE) && fifo_empty);

  // A new frame is fetched either from idle or right at the end of a stop bit,
  // which is what keeps consecutive frames gap-free.
  always_comb begin
    bit_done = (cnt_q == CNT_LAST);
    fifo_pop = !fifo_empty &&
               ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_done));
  end

  // Frame sequencer: state, bit timing, shifter and the registered line driver.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      tx_serial_q <= LINE_IDLE;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      // Bit-period counter: held at zero while idle, wraps at the end of each bit.
      if ((state_q == ST_IDLE) || bit_done) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_ONE;
      end

      // Capture the head byte for the whole frame when it leaves the FIFO.
      if (fifo_pop) begin
        shift_q <= fifo_head;
`ifdef UART_TX_PARITY_EN
        parity_q <= even_parity(fifo_head);
`endif
      end

      case (state_q)
        ST_IDLE: begin
          if (fifo_pop) begin
            state_q     <= ST_START;
            tx_serial_q <= LINE_START;
          end
        end

        ST_START: begin
          if (bit_done) begin
            state_q     <= ST_DATA;
            bit_idx_q   <= '0;
            tx_serial_q <= shift_q[0];
          end
        end

        ST_DATA: begin
          if (bit_done) begin
            if (bit_idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_q     <= ST_PARITY;
              tx_serial_q <= parity_q;
`else
              state_q     <= ST_STOP;
              tx_serial_q <= LINE_STOP;
`endif
            end else begin
              bit_idx_q   <= bit_idx_q + IDX_ONE;
              shift_q     <= {1'b0, shift_q[DATA_BITS-1:1]};
              tx_serial_q <= shift_q[1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_done) begin
            state_q     <= ST_STOP;
            tx_serial_q <= LINE_STOP;
          end
        end
`endif

        ST_STOP: begin
          if (bit_done) begin
            if (fifo_pop) begin
              state_q     <= ST_START;
              tx_serial_q <= LINE_START;
            end else begin
              state_q     <= ST_IDLE;
              tx_serial_q <= LINE_IDLE;
            end
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          tx_serial_q <= LINE_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx (CLKS_PER_BIT=4, 4-deep FIFO).
// A cycle-level reference model (byte queue + expected line waveform) checks
// every cycle; directed table vectors and corner sequences add explicit checks.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int LOG2  = 2;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx_serial;
  logic       tx_busy;
  logic [LOG2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  uart_tx #(
    .CLKS_PER_BIT    (CPB),
    .FIFO_DEPTH_LOG2 (LOG2)
  ) dut (
    .CLK        (CLK),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_serial  (tx_serial),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         wave[$];   // expected line level, wave[0] = current cycle
  logic [7:0] fq[$];     // bytes waiting in the FIFO
  bit         model_on = 0;
  bit         do_pop;
  bit         do_push;

  function automatic bit frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == FB - 1) return 1'b1;
    return ^b;
  endfunction

  function automatic void append_frame(input logic [7:0] b);
    for (int k = 0; k < FB; k++)
      for (int j = 0; j < CPB; j++)
        wave.push_back(frame_bit(b, k));
  endfunction

  always @(posedge CLK) begin
    if (rst) begin
      wave.delete();
      fq.delete();
      model_on = 1;
    end else if (model_on) begin
      do_pop  = (fq.size() > 0) && (wave.size() <= 1);
      do_push = tx_valid && (fq.size() < DEPTH);
      if (wave.size() > 0) void'(wave.pop_front());
      if (do_pop) append_frame(fq.pop_front());
      if (do_push) begin
        fq.push_back(tx_data);
        $display("push 0x%02h queued=%0d", tx_data, fq.size());
      end
    end
    #1;
    if (model_on) begin
      check("serial", {31'b0, tx_serial}, (wave.size() > 0) ? {31'b0, wave[0]} : 32'd1);
      check("fifo_count", {29'b0, fifo_count}, fq.size());
      check("tx_ready", {31'b0, tx_ready}, (fq.size() != DEPTH) ? 32'd1 : 32'd0);
      check("tx_busy", {31'b0, tx_busy}, (wave.size() > 0 || fq.size() > 0) ? 32'd1 : 32'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle();
    int n = 0;
    while (tx_busy && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    check("idle_timeout", {31'b0, tx_busy}, 32'd0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  vec_t tbl[6];
  logic [7:0] burst[5];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'hA5, 1'b0};
    tbl[1] = '{8'h01, 1'b1};
    tbl[2] = '{8'hFF, 1'b0};
    tbl[3] = '{8'h00, 1'b0};
    tbl[4] = '{8'h80, 1'b1};
    tbl[5] = '{8'h6B, 1'b1};
    burst[0] = 8'h22; burst[1] = 8'h33; burst[2] = 8'h44; burst[3] = 8'h55; burst[4] = 8'h66;

    // Reset state.
    repeat (3) @(negedge CLK);
    check("rst_serial", {31'b0, tx_serial}, 32'd1);
    check("rst_busy", {31'b0, tx_busy}, 32'd0);
    check("rst_count", {29'b0, fifo_count}, 32'd0);
    check("rst_ready", {31'b0, tx_ready}, 32'd1);
    rst = 1'b0;

    // Table-driven single frames: exact latency, bit values, frame length.
    for (int i = 0; i < 6; i++) begin
      logic eb;
      wait_idle();
      @(negedge CLK);
      tx_valid = 1'b1;
      tx_data  = tbl[i].data;
      @(negedge CLK);                 // cycle N+1
      tx_valid = 1'b0;
      check("pre_start_serial", {31'b0, tx_serial}, 32'd1);
      check("pre_start_busy", {31'b0, tx_busy}, 32'd1);
      @(negedge CLK);                 // cycle N+2: start bit begins
      for (int k = 0; k < FB; k++) begin
        if (k == 0)            eb = 1'b0;
        else if (k <= 8)       eb = tbl[i].data[k-1];
        else if (k == FB - 1)  eb = 1'b1;
        else                   eb = tbl[i].par;
        check("bit_first", {31'b0, tx_serial}, {31'b0, eb});
        repeat (CPB - 1) @(negedge CLK);
        check("bit_last", {31'b0, tx_serial}, {31'b0, eb});
        check("busy_in_frame", {31'b0, tx_busy}, 32'd1);
        @(negedge CLK);
      end
      check("after_frame_busy", {31'b0, tx_busy}, 32'd0);
      check("after_frame_serial", {31'b0, tx_serial}, 32'd1);
      $display("frame 0x%02h sent", tbl[i].data);
    end

    // Burst of six pushes into an idle transmitter: five accepted, sixth dropped.
    wait_idle();
    @(negedge CLK);                   // cycle N
    tx_valid = 1'b1;
    tx_data  = 8'h11;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      tx_data = burst[i];
    end
    @(negedge CLK);                   // cycle N+6
    tx_valid = 1'b0;
    check("burst_count", {29'b0, fifo_count}, 32'd4);
    check("burst_ready", {31'b0, tx_ready}, 32'd0);
    // Push into a full FIFO on the cycle it pops (last stop cycle of frame 1).
    repeat (35) @(negedge CLK);       // cycle N+41
    tx_valid = 1'b1;
    tx_data  = 8'h77;
    check("full_pop_count_before", {29'b0, fifo_count}, 32'd4);
    check("full_pop_stop", {31'b0, tx_serial}, 32'd1);
    @(negedge CLK);                   // cycle N+42
    tx_valid = 1'b0;
    check("full_pop_count_after", {29'b0, fifo_count}, 32'd3);
    check("full_pop_ready", {31'b0, tx_ready}, 32'd1);
    check("no_gap_start", {31'b0, tx_serial}, 32'd0);
    // Push 0x00 on the STOP->START pop with one byte queued.
    repeat (119) @(negedge CLK);      // cycle N+161
    check("push_pop_count_before", {29'b0, fifo_count}, 32'd1);
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    @(negedge CLK);                   // cycle N+162
    tx_valid = 1'b0;
    check("push_pop_count_after", {29'b0, fifo_count}, 32'd1);
    repeat (48) @(negedge CLK);       // cycle N+210: data bit 1 of the 0x00 frame
    check("zero_frame_bit", {31'b0, tx_serial}, 32'd0);
    check("zero_frame_busy", {31'b0, tx_busy}, 32'd1);

    // Reset during data bit 3 of 0xFF with two bytes queued.
    wait_idle();
    @(negedge CLK);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    @(negedge CLK);
    tx_data  = 8'h12;
    @(negedge CLK);
    tx_data  = 8'h34;
    @(negedge CLK);                   // cycle N+3
    tx_valid = 1'b0;
    repeat (16) @(negedge CLK);       // cycle N+19
    check("pre_rst_count", {29'b0, fifo_count}, 32'd2);
    check("pre_rst_busy", {31'b0, tx_busy}, 32'd1);
    rst = 1'b1;
    @(negedge CLK);
    check("abort_serial", {31'b0, tx_serial}, 32'd1);
    check("abort_count", {29'b0, fifo_count}, 32'd0);
    check("abort_busy", {31'b0, tx_busy}, 32'd0);
    check("abort_ready", {31'b0, tx_ready}, 32'd1);
    rst = 1'b0;
    repeat (80) @(negedge CLK);
    check("post_abort_busy", {31'b0, tx_busy}, 32'd0);
    check("post_abort_serial", {31'b0, tx_serial}, 32'd1);

    // Randomised traffic with rare resets; the model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      tx_valid = ($urandom_range(0, 9) == 0);
      tx_data  = 8'($urandom);
      rst      = ($urandom_range(0, 999) == 0);
    end
    @(negedge CLK);
    tx_valid = 1'b0;
    rst      = 1'b0;
    wait_idle();
    repeat (5) @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
